// File: rtl/game_dialog_text_src.sv
// game_dialog_text_src: dialog text buffer with typewriter reveal, answering char_xy/char_line
// requests with font rows through a fixed 3-cycle pipeline into a registered font ROM.
module game_dialog_text_src #(
  parameter int REVEAL_DIV = 2,
  parameter logic [6:0] BLANK_CODE = 7'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_xy,
  input  logic [3:0]  char_line,
  output logic [7:0]  char_line_pixels,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [6:0]  wr_data,
  input  logic [8:0]  text_len,
  input  logic        start,
  input  logic        skip,
  input  logic        clear,
  input  logic        frame_tick,
  output logic        busy,
  output logic        reveal_done
);
  typedef enum logic [1:0] {IDLE, REVEAL, SHOWN, CLEAR} state_t;
  localparam logic [3:0] DIV_M1 = 4'(REVEAL_DIV - 1);
  state_t r_state, w_state_n;
  logic [8:0] r_reveal, w_reveal_n, r_len, w_len_n;
  logic [3:0] r_div, w_div_n;
  logic [7:0] r_clr, w_clr_n;
  logic [6:0] r_mem [256];
  logic [6:0] r_code;
  logic [3:0] r_line;
  logic       r_vis, r_vis2;
  assign font_addr = {r_code, r_line};
  always_comb begin
    w_state_n = r_state;
    w_reveal_n = r_reveal;
    w_len_n = r_len;
    w_div_n = r_div;
    w_clr_n = r_clr;
    if (r_state == CLEAR) begin
      w_reveal_n = '0;
      w_clr_n = clear ? 8'd0 : r_clr + 8'd1;
      if (!clear && r_clr == 8'hff) w_state_n = IDLE;
    end else if (clear) begin
      w_state_n = CLEAR;
      w_clr_n = '0;
      w_reveal_n = '0;
    end else if (start) begin
      w_state_n = REVEAL;
      w_len_n = text_len;
      w_reveal_n = '0;
      w_div_n = '0;
    end else if (r_state == REVEAL) begin
      if (skip) w_reveal_n = r_len;
      else if (frame_tick && r_reveal < r_len) begin
        w_div_n = (r_div == DIV_M1) ? 4'd0 : r_div + 4'd1;
        w_reveal_n = (r_div == DIV_M1) ? r_reveal + 9'd1 : r_reveal;
      end
      if (w_reveal_n >= r_len) w_state_n = SHOWN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_reveal <= '0;
      r_len <= '0;
      r_div <= '0;
      r_clr <= '0;
      busy <= 1'b0;
      reveal_done <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_reveal <= w_reveal_n;
      r_len <= w_len_n;
      r_div <= w_div_n;
      r_clr <= w_clr_n;
      busy <= (w_state_n == REVEAL) || (w_state_n == CLEAR);
      reveal_done <= (w_state_n == SHOWN);
    end
  end
  // the sweep owns the write port while clearing; reset never touches the buffer
  always_ff @(posedge clk) begin
    if (!rst && r_state == CLEAR) r_mem[r_clr] <= BLANK_CODE;
    else if (!rst && wr_en) r_mem[wr_addr] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code <= '0;
      r_line <= '0;
      r_vis <= 1'b0;
      r_vis2 <= 1'b0;
      char_line_pixels <= '0;
    end else begin
      r_code <= r_mem[char_xy];
      r_line <= char_line;
      r_vis <= {1'b0, char_xy} < r_reveal;
      r_vis2 <= r_vis;
      char_line_pixels <= r_vis2 ? font_data : 8'h00;
    end
  end
endmodule

// File: tb/tb_game_dialog_text_src.sv
// tb_game_dialog_text_src: directed scenario tests for the dialog text source with a
// registered font ROM model whose row is {line, code[6:3]}.
module tb_game_dialog_text_src;
  logic clk = 0;
  logic rst = 1;
  logic [7:0] char_xy = 0;
  logic [3:0] char_line = 0;
  logic [7:0] char_line_pixels;
  logic [10:0] font_addr;
  logic [7:0] font_data;
  logic wr_en = 0;
  logic [7:0] wr_addr = 0;
  logic [6:0] wr_data = 0;
  logic [8:0] text_len = 0;
  logic start = 0, skip = 0, clear = 0, frame_tick = 0;
  logic busy, reveal_done;
  int n_cmp = 0, n_bad = 0;
  logic [6:0] bm [256];

  game_dialog_text_src dut (
    .clk(clk), .rst(rst), .char_xy(char_xy), .char_line(char_line),
    .char_line_pixels(char_line_pixels), .font_addr(font_addr), .font_data(font_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .text_len(text_len),
    .start(start), .skip(skip), .clear(clear), .frame_tick(frame_tick),
    .busy(busy), .reveal_done(reveal_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [6:0] code, input logic [3:0] line);
    return {line, code[6:3]};
  endfunction

  always_ff @(posedge clk) font_data <= rom(font_addr[10:4], font_addr[3:0]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [6:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
    bm[a] = d;
  endtask

  task automatic pulse_frame();
    frame_tick = 1;
    tick();
    frame_tick = 0;
  endtask

  task automatic do_start(input logic [8:0] len);
    text_len = len; start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    n_cmp++;
    if (char_line_pixels !== 8'h00) begin n_bad++; $display("FAIL reset_pixels got %h want 00", char_line_pixels); end
    n_cmp++;
    if (font_addr !== 11'h000) begin n_bad++; $display("FAIL reset_font_addr got %h want 000", font_addr); end
    n_cmp++;
    if ({busy, reveal_done} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {busy, reveal_done}); end
  endtask

  task automatic test_reveal();
    wr(8'd0, 7'h48);
    wr(8'd1, 7'h49);
    do_start(9'd2);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL reveal_busy got %b want 1", busy); end
    char_xy = 0; char_line = 5;
    tick(); tick(); tick();
    n_cmp++;
    if (char_line_pixels !== 8'h00) begin n_bad++; $display("FAIL reveal_hidden got %h want 00", char_line_pixels); end
    pulse_frame();
    pulse_frame();
    tick(); tick();
    n_cmp++;
    if (char_line_pixels !== 8'h00) begin n_bad++; $display("FAIL reveal_lag2 got %h want 00", char_line_pixels); end
    tick();
    n_cmp++;
    if (char_line_pixels !== 8'h59) begin n_bad++; $display("FAIL reveal_lag3 got %h want 59", char_line_pixels); end
    pulse_frame();
    n_cmp++;
    if (reveal_done !== 1'b0) begin n_bad++; $display("FAIL reveal_done_early got %b want 0", reveal_done); end
    pulse_frame();
    n_cmp++;
    if ({busy, reveal_done} !== 2'b01) begin n_bad++; $display("FAIL reveal_done got %b want 01", {busy, reveal_done}); end
  endtask

  task automatic test_stream();
    for (int i = 2; i < 32; i++) wr(8'(i), 7'(8'h41 + 8'(i)));
    char_line = 3;
    for (int j = 0; j < 34; j++) begin
      if (j < 32) char_xy = 8'(j);
      tick();
      if (j >= 2) begin
        n_cmp++;
        if (char_line_pixels !== ((j - 2) < 2 ? rom(bm[j - 2], 4'd3) : 8'h00)) begin
          n_bad++;
          $display("FAIL stream_xy%0d got %h want %h", j - 2, char_line_pixels,
                   (j - 2) < 2 ? rom(bm[j - 2], 4'd3) : 8'h00);
        end
      end
    end
  endtask

  task automatic test_skip();
    wr(8'd255, 7'h5A);
    do_start(9'd256);
    pulse_frame();
    skip = 1;
    tick();
    skip = 0;
    n_cmp++;
    if ({busy, reveal_done} !== 2'b01) begin n_bad++; $display("FAIL skip_shown got %b want 01", {busy, reveal_done}); end
    char_xy = 255; char_line = 2;
    tick();
    n_cmp++;
    if (font_addr !== {7'h5A, 4'd2}) begin n_bad++; $display("FAIL skip_font_addr got %h want %h", font_addr, {7'h5A, 4'd2}); end
    tick(); tick();
    n_cmp++;
    if (char_line_pixels !== 8'h2B) begin n_bad++; $display("FAIL skip_xy255 got %h want 2b", char_line_pixels); end
  endtask

  task automatic test_priority_clear();
    int n;
    logic [7:0] cells [5];
    cells = '{8'd0, 8'd1, 8'd31, 8'd128, 8'd255};
    text_len = 5; start = 1; skip = 1;
    tick();
    start = 0; skip = 0;
    n_cmp++;
    if ({busy, reveal_done} !== 2'b10) begin n_bad++; $display("FAIL start_skip_state got %b want 10", {busy, reveal_done}); end
    char_xy = 0; char_line = 5;
    tick(); tick(); tick();
    n_cmp++;
    if (char_line_pixels !== 8'h00) begin n_bad++; $display("FAIL start_skip_cnt0 got %h want 00", char_line_pixels); end
    clear = 1; start = 1;
    tick();
    clear = 0; start = 0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != 256) begin n_bad++; $display("FAIL clear_busy_cycles got %0d want 256", n); end
    n_cmp++;
    if ({busy, reveal_done} !== 2'b00) begin n_bad++; $display("FAIL clear_idle got %b want 00", {busy, reveal_done}); end
    for (int i = 0; i < 256; i++) bm[i] = 7'h20;
    char_line = 0;
    foreach (cells[k]) begin
      char_xy = cells[k];
      tick();
      n_cmp++;
      if (font_addr !== 11'h200) begin n_bad++; $display("FAIL clear_cell%0d got %h want 200", cells[k], font_addr); end
    end
  endtask

  task automatic test_rw_collision();
    char_xy = 7; char_line = 4;
    wr_en = 1; wr_addr = 7; wr_data = 7'h41;
    tick();
    wr_en = 0;
    bm[7] = 7'h41;
    n_cmp++;
    if (font_addr !== {7'h20, 4'd4}) begin n_bad++; $display("FAIL collide_old got %h want %h", font_addr, {7'h20, 4'd4}); end
    tick();
    n_cmp++;
    if (font_addr !== {7'h41, 4'd4}) begin n_bad++; $display("FAIL collide_new got %h want %h", font_addr, {7'h41, 4'd4}); end
  endtask

  task automatic test_rst_mid();
    do_start(9'd10);
    char_xy = 2; char_line = 1;
    for (int i = 0; i < 6; i++) pulse_frame();
    tick(); tick(); tick();
    n_cmp++;
    if (char_line_pixels !== 8'h14) begin n_bad++; $display("FAIL rst_pre_visible got %h want 14", char_line_pixels); end
    rst = 1;
    tick();
    rst = 0;
    n_cmp++;
    if ({char_line_pixels, font_addr, busy, reveal_done} !== 21'h0) begin
      n_bad++;
      $display("FAIL rst_outputs got px=%h fa=%h b=%b d=%b want all 0", char_line_pixels, font_addr, busy, reveal_done);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (char_line_pixels !== 8'h00) begin n_bad++; $display("FAIL rst_hidden got %h want 00", char_line_pixels); end
    do_start(9'd10);
    char_xy = 7; char_line = 4;
    for (int i = 0; i < 16; i++) pulse_frame();
    tick(); tick(); tick();
    n_cmp++;
    if (char_line_pixels !== rom(bm[7], 4'd4)) begin n_bad++; $display("FAIL rst_buffer_kept got %h want %h", char_line_pixels, rom(bm[7], 4'd4)); end
  endtask

  initial begin
    test_reset();
    test_reveal();
    test_stream();
    test_skip();
    test_priority_clear();
    test_rw_collision();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/game_dialog_text_src.md
Name: game_dialog_text_src

Overview:
Character-source responder for the dialog overlay text interface. It answers each char_xy/char_line request with the 8-pixel font row of the character stored at that cell of a writable 32x8 dialog text buffer. It adds a typewriter reveal: characters appear one at a time, paced by frame ticks. It sits between the dialog overlay (requester) and the shared synchronous font ROM.

Parameters:
REVEAL_DIV, 2, frames per revealed character (range 1..15)
BLANK_CODE, 7'h20, character code written to every buffer cell by clear

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
char_xy  in  8  request cell: [4:0] column, [7:5] row; linear index = char_xy
char_line  in  4  request font line 0..15
char_line_pixels  out  8  font row for the request, MSB = leftmost pixel
font_addr  out  11  {char_code[6:0], line[3:0]} to the font ROM
font_data  in  8  font ROM row, registered in the ROM, valid 1 cycle after font_addr
wr_en  in  1  buffer write strobe
wr_addr  in  8  buffer write index
wr_data  in  7  buffer write character code
text_len  in  9  number of characters to reveal (0..256), sampled on start
start  in  1  1-cycle pulse: begin reveal from index 0
skip  in  1  1-cycle pulse: reveal all remaining characters immediately
clear  in  1  1-cycle pulse: hide text, fill buffer with BLANK_CODE
frame_tick  in  1  1-cycle pulse once per frame (vsync edge)
busy  out  1  high in REVEAL and CLEAR
reveal_done  out  1  high in SHOWN

Behaviour:
- Reset values: char_line_pixels=0, font_addr=0, busy=0, reveal_done=0; state IDLE; reveal_cnt=0; div_cnt=0; len_q=0. Buffer contents are undefined after reset; software clears or writes the buffer.
- Read pipeline, fixed latency of 3 cycles from request to char_line_pixels:
  - c0: buffer read at char_xy; buffer is read-first, so a same-cycle write to the same address returns the old code.
  - c1: code_q, line_q and vis_q = (char_xy < reveal_cnt) are registered; font_addr = {code_q, line_q} is registered-driven, with no combinational path from the inputs.
  - c2: font_data arrives; vis_q2 is the one-cycle delay of vis_q.
  - c3: char_line_pixels <= vis_q2 ? font_data : 8'h00.
  - The pipeline runs every cycle regardless of state, so back-to-back requests produce back-to-back answers.
- State machine IDLE, REVEAL, SHOWN, CLEAR; event priority is clear > start > skip > frame_tick.
- IDLE: reveal_cnt=0, so every character is hidden.
  - start -> REVEAL with len_q=text_len, reveal_cnt=0, div_cnt=0.
  - clear -> CLEAR.
- REVEAL, on frame_tick:
  - if div_cnt==REVEAL_DIV-1, then div_cnt=0 and reveal_cnt+1; otherwise div_cnt+1.
  - When reveal_cnt reaches len_q, move to SHOWN. The comparison is 9-bit; reveal_cnt saturates at len_q.
  - skip: reveal_cnt=len_q, then SHOWN on the next cycle.
  - start: restart from 0 with a newly sampled len.
- REVEAL with text_len=0: go to SHOWN on the next cycle, with nothing visible.
- SHOWN: reveal_cnt holds.
  - start restarts the reveal.
  - clear -> CLEAR.
  - skip and frame_tick are ignored.
- CLEAR:
  - reveal_cnt=0.
  - An internal 8-bit counter writes BLANK_CODE to indices 0..255, one per cycle (256 cycles), then returns to IDLE.
  - External wr_en is ignored during CLEAR.
  - start during CLEAR is ignored.
  - clear during CLEAR restarts the sweep at index 0.
- External write outside CLEAR: takes effect on the next clock; the address wraps within 8 bits.
- reveal_done is high exactly in SHOWN; busy is high in REVEAL or CLEAR. Both are registered from the state.
- rst mid-operation: returns to IDLE next clock, hides all text, zeroes the pipeline outputs; the buffer is untouched.

Test Plan:
1. Write "HI" (0x48,0x49) at indices 0,1; start with text_len=2, REVEAL_DIV=2; request xy=0, line=5 -> pixels 0 until 2 frame_ticks, then ROM row for {0x48,5} appears exactly 3 cycles after the request; reveal_done after 4 ticks.
2. Stream requests xy=0..31, one per cycle, in SHOWN -> 32 consecutive outputs, each matching model ROM[{buf[i],line}] with 3-cycle lag; xy>=len_q outputs 0x00.
3. start text_len=256, then skip after 1 tick -> next cycle state SHOWN, reveal_cnt=256; xy=255 is visible.
4. start and skip in the same cycle -> REVEAL with reveal_cnt=0 (start wins); clear and start in the same cycle -> CLEAR, busy=1 for 256 cycles, then every cell reads BLANK_CODE 0x20.
5. Write 0x41 to addr 7 while requesting xy=7 in the same cycle -> font_addr carries the old code; a request on the next cycle carries 0x41.
6. Assert rst during REVEAL at reveal_cnt=3 -> next cycle all outputs 0, state IDLE; buffer contents are preserved and visible again after a new start.
